// File: rtl/dff_chain_sequencer_pkg.sv
// Shared definitions for the DFF chain sequencer: default sizing and FSM states.
package dff_seq_defs;

   localparam int unsigned DEFAULT_WIDTH = 8;
   localparam int unsigned DEFAULT_DEPTH = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/dff_chain_sequencer_if.sv
// Handshake and serial-chain signals between the sequencer (slave) and its environment (master).
interface dff_chain_sequencer_if #(
   parameter int unsigned WIDTH = dff_seq_defs::DEFAULT_WIDTH
);

   logic             start;
   logic [WIDTH-1:0] din;
   logic             abort;
   logic             q_in;
   logic             ready;
   logic             busy;
   logic             D;
   logic             shift_en;
   logic [WIDTH-1:0] dout;
   logic             done;

   modport master (
      output start, din, abort, q_in,
      input  ready, busy, D, shift_en, dout, done
   );

   modport slave (
      input  start, din, abort, q_in,
      output ready, busy, D, shift_en, dout, done
   );

endinterface

// File: rtl/dff_chain_sequencer_piso_sipo_reg.sv
// Transmit PISO and receive SIPO shift registers for the chain sequencer.
module piso_sipo_reg #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_tx_shift,
   input  logic             i_rx_shift,
   input  logic             i_q,
   output logic             o_tx_next,
   output logic [WIDTH-2:0] o_rx
);

   localparam int unsigned RXW = WIDTH - 1;

   logic [WIDTH-1:0] r_tx;
   logic [RXW-1:0]   r_rx;

   // rx keeps only WIDTH-1 bits: the final capture goes straight into dout
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_tx <= '0;
         r_rx <= '0;
      end else if (i_load) begin
         r_tx <= i_din;
         r_rx <= '0;
      end else begin
         if (i_tx_shift) r_tx <= r_tx << 1;
         if (i_rx_shift) r_rx <= (r_rx << 1) | RXW'(i_q);
      end
   end

   assign o_tx_next = r_tx[WIDTH-2];
   assign o_rx      = r_rx;

endmodule

// File: rtl/dff_chain_sequencer.sv
// Sequencer that shifts a word MSB-first through an external DFF chain and recaptures it.
module dff_chain_sequencer
   import dff_seq_defs::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH,
   parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
   input logic                  clk,
   input logic                  rst_n,
   dff_chain_sequencer_if.slave bus
);

   localparam int unsigned LAST  = WIDTH + DEPTH - 1;
   localparam int unsigned CNT_W = $clog2(WIDTH + DEPTH + 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_D;
   logic             r_shift_en;
   logic             r_done;
   logic [WIDTH-1:0] r_dout;

   logic             w_load;
   logic             w_in_shift;
   logic             w_rx_shift;
   logic             w_tx_next;
   logic [WIDTH-2:0] w_rx;

   assign w_load     = (r_state == IDLE) && bus.start && !bus.abort;
   assign w_in_shift = (r_state == SHIFT) && !bus.abort;
   assign w_rx_shift = w_in_shift && (r_cnt >= CNT_W'(DEPTH));

   piso_sipo_reg #(.WIDTH(WIDTH)) u_regs (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_load),
      .i_din      (bus.din),
      .i_tx_shift (w_in_shift),
      .i_rx_shift (w_rx_shift),
      .i_q        (bus.q_in),
      .o_tx_next  (w_tx_next),
      .o_rx       (w_rx)
   );

   // D is registered, so each edge loads the bit for the following cycle;
   // the MSB is taken from din directly on the accepting edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_D        <= 1'b0;
         r_shift_en <= 1'b0;
         r_done     <= 1'b0;
         r_dout     <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (w_load) begin
                  r_state    <= SHIFT;
                  r_cnt      <= '0;
                  r_D        <= bus.din[WIDTH-1];
                  r_shift_en <= 1'b1;
               end
            end
            SHIFT: begin
               if (bus.abort) begin
                  r_state    <= IDLE;
                  r_shift_en <= 1'b0;
                  r_D        <= 1'b0;
               end else if (r_cnt == CNT_W'(LAST)) begin
                  r_state    <= DONE;
                  r_shift_en <= 1'b0;
                  r_D        <= 1'b0;
                  r_done     <= 1'b1;
                  r_dout     <= {w_rx, bus.q_in};
               end else begin
                  r_cnt <= r_cnt + 1'b1;
                  r_D   <= w_tx_next;
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.ready    = (r_state == IDLE);
   assign bus.busy     = (r_state == SHIFT);
   assign bus.D        = r_D;
   assign bus.shift_en = r_shift_en;
   assign bus.done     = r_done;
   assign bus.dout     = r_dout;

endmodule
